// File: rtl/decode_regfile_unit.sv
// -----------------------------------------------------------------------------
// decode_regfile_unit
//
// MIPS-style instruction decode stage: a combinational decoder that produces
// control flags, the ALU opcode and the branch/jump target, alongside a
// 32 x 32 register file with three combinational read ports and one
// synchronous write port.
//
// Ports
//   CLK                     in   1   register-file write clock
//   RESET                   in   1   async active-low, clears register file
//   Instr                   in  32   instruction being decoded
//   Instr_PC_Plus4          in  32   PC+4 of Instr
//   RsValue                 in  32   forwarded rs value (jump-register target)
//   RegA/RegB/RegC          in   5   read addresses
//   DataA/DataB/DataC       out 32   read data (r0 always reads 0)
//   WriteReg                in   5   write address
//   WriteData               in  32   write data
//   Write                   in   1   write enable
//   Link ... Syscall        out  1   decode flags
//   ALUControl              out  6   ALU opcode
//   NextInstructionAddress  out 32   branch/jump target
// -----------------------------------------------------------------------------
module decode_regfile_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] Instr_PC_Plus4,
  input  logic [31:0] RsValue,
  input  logic [4:0]  RegA,
  input  logic [4:0]  RegB,
  input  logic [4:0]  RegC,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  output logic [31:0] DataC,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic        Write,
  output logic        Link,
  output logic        RegDest,
  output logic        Jump,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        JumpRegister,
  output logic        SignOrZero,
  output logic        Syscall,
  output logic [5:0]  ALUControl,
  output logic [31:0] NextInstructionAddress
);

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_LL     = 6'h30;
  localparam logic [5:0] OP_SC     = 6'h38;

  // R-type function codes
  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // Link instructions reuse the ALU as an unsigned add to form the return address
  localparam logic [5:0] ALU_LINK  = 6'b100001;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;

  assign op    = Instr[31:26];
  assign funct = Instr[5:0];
  assign rt    = Instr[20:16];

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so unlisted
    // opcodes fall through to all-zero and no latch is inferred.
    Link         = 1'b0;
    RegDest      = 1'b0;
    Jump         = 1'b0;
    Branch       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    ALUSrc       = 1'b0;
    RegWrite     = 1'b0;
    JumpRegister = 1'b0;
    SignOrZero   = 1'b0;
    Syscall      = 1'b0;
    ALUControl   = 6'b000000;

    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
            RegDest    = 1'b1;
            RegWrite   = 1'b1;
            ALUControl = funct;
          end
          F_JR: begin
            Jump         = 1'b1;
            JumpRegister = 1'b1;
          end
          F_JALR: begin
            Jump         = 1'b1;
            JumpRegister = 1'b1;
            Link         = 1'b1;
            RegDest      = 1'b1;
            RegWrite     = 1'b1;
            ALUControl   = ALU_LINK;
          end
          F_SYSCALL: begin
            Syscall    = 1'b1;
            ALUControl = 6'b001100;
          end
          default: ;
        endcase
      end

      OP_J: Jump = 1'b1;

      OP_JAL: begin
        Jump       = 1'b1;
        Link       = 1'b1;
        RegWrite   = 1'b1;
        ALUControl = ALU_LINK;
      end

      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        Branch     = 1'b1;
        SignOrZero = 1'b1;
      end

      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: begin
            Branch     = 1'b1;
            SignOrZero = 1'b1;
          end
          RT_BLTZAL, RT_BGEZAL: begin
            Branch     = 1'b1;
            SignOrZero = 1'b1;
            Link       = 1'b1;
            RegWrite   = 1'b1;
            ALUControl = ALU_LINK;
          end
          default: ;
        endcase
      end

      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        RegWrite   = 1'b1;
        ALUSrc     = 1'b1;
        SignOrZero = 1'b1;
        // 0x08..0x0B map onto the R-type ADD/ADDU/SLT/SLTU codes
        ALUControl = (op == OP_ADDI)  ? 6'b100000 :
                     (op == OP_ADDIU) ? 6'b100001 :
                     (op == OP_SLTI)  ? 6'b101010 : 6'b101011;
      end

      OP_ANDI, OP_ORI, OP_XORI: begin
        RegWrite   = 1'b1;
        ALUSrc     = 1'b1;
        ALUControl = (op == OP_ANDI) ? 6'b100100 :
                     (op == OP_ORI)  ? 6'b100101 : 6'b100110;
      end

      OP_LUI: begin
        RegWrite   = 1'b1;
        ALUSrc     = 1'b1;
        ALUControl = 6'b011111;
      end

      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        MemRead    = 1'b1;
        RegWrite   = 1'b1;
        ALUSrc     = 1'b1;
        SignOrZero = 1'b1;
        ALUControl = {2'b11, op[3:0]};
      end

      OP_LL: begin
        MemRead    = 1'b1;
        RegWrite   = 1'b1;
        ALUSrc     = 1'b1;
        SignOrZero = 1'b1;
        ALUControl = 6'b101000;
      end

      OP_SB, OP_SH, OP_SW: begin
        MemWrite   = 1'b1;
        ALUSrc     = 1'b1;
        SignOrZero = 1'b1;
        ALUControl = {2'b11, op[3:0]};
      end

      // SC writes its success flag back into rt
      OP_SC: begin
        MemWrite   = 1'b1;
        ALUSrc     = 1'b1;
        SignOrZero = 1'b1;
        RegWrite   = 1'b1;
        ALUControl = 6'b110110;
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Target address: register jump, pseudo-direct jump, else PC-relative
  // branch target (computed even for non-branches; consumers gate on flags).
  // ---------------------------------------------------------------------------
  logic [31:0] branch_offset;
  assign branch_offset = {{14{Instr[15]}}, Instr[15:0], 2'b00};

  always_comb begin
    if (JumpRegister)
      NextInstructionAddress = RsValue;
    else if (Jump)
      NextInstructionAddress = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
    else
      NextInstructionAddress = Instr_PC_Plus4 + branch_offset;
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] regs [32];

  // NOTE: the whole array sits under the async reset because software relies
  // on every register reading zero after reset; this forces flops, not RAM.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together at the edge and readers see the pre-edge value.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (Write && (WriteReg != 5'd0)) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // No write bypass: a read in the write cycle returns the stored value
  assign DataA = (RegA == 5'd0) ? 32'd0 : regs[RegA];
  assign DataB = (RegB == 5'd0) ? 32'd0 : regs[RegB];
  assign DataC = (RegC == 5'd0) ? 32'd0 : regs[RegC];

endmodule

// File: tb/tb_decode_regfile_unit.sv
// -----------------------------------------------------------------------------
// tb_decode_regfile_unit
//
// Directed self-checking bench for decode_regfile_unit: register-file reset,
// write/read timing, r0 behaviour, async reset override, and decoder vectors
// with hand-computed flags, ALU opcodes and target addresses.
// -----------------------------------------------------------------------------
module tb_decode_regfile_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] Instr;
  logic [31:0] Instr_PC_Plus4;
  logic [31:0] RsValue;
  logic [4:0]  RegA;
  logic [4:0]  RegB;
  logic [4:0]  RegC;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic [31:0] DataC;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        Write;
  logic        Link;
  logic        RegDest;
  logic        Jump;
  logic        Branch;
  logic        MemRead;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic        JumpRegister;
  logic        SignOrZero;
  logic        Syscall;
  logic [5:0]  ALUControl;
  logic [31:0] NextInstructionAddress;

  int checks = 0;
  int errors = 0;

  decode_regfile_unit dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .Instr                  (Instr),
    .Instr_PC_Plus4         (Instr_PC_Plus4),
    .RsValue                (RsValue),
    .RegA                   (RegA),
    .RegB                   (RegB),
    .RegC                   (RegC),
    .DataA                  (DataA),
    .DataB                  (DataB),
    .DataC                  (DataC),
    .WriteReg               (WriteReg),
    .WriteData              (WriteData),
    .Write                  (Write),
    .Link                   (Link),
    .RegDest                (RegDest),
    .Jump                   (Jump),
    .Branch                 (Branch),
    .MemRead                (MemRead),
    .MemWrite               (MemWrite),
    .ALUSrc                 (ALUSrc),
    .RegWrite               (RegWrite),
    .JumpRegister           (JumpRegister),
    .SignOrZero             (SignOrZero),
    .Syscall                (Syscall),
    .ALUControl             (ALUControl),
    .NextInstructionAddress (NextInstructionAddress)
  );

  // Flag order: Link RegDest Jump Branch MemRead MemWrite ALUSrc RegWrite
  //             JumpRegister SignOrZero Syscall
  logic [10:0] flags;
  assign flags = {Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc,
                  RegWrite, JumpRegister, SignOrZero, Syscall};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_decode(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic [31:0] rs,
                              input logic [10:0] exp_flags, input logic [5:0] exp_alu,
                              input logic [31:0] exp_nia);
    Instr          = instr;
    Instr_PC_Plus4 = pc4;
    RsValue        = rs;
    #1;
    check({tag, " flags"}, {21'd0, flags},      {21'd0, exp_flags});
    check({tag, " alu"},   {26'd0, ALUControl}, {26'd0, exp_alu});
    check({tag, " nia"},   NextInstructionAddress, exp_nia);
  endtask

  initial begin
    RESET          = 1'b0;
    Instr          = 32'd0;
    Instr_PC_Plus4 = 32'd0;
    RsValue        = 32'd0;
    RegA           = 5'd0;
    RegB           = 5'd0;
    RegC           = 5'd0;
    WriteReg       = 5'd3;
    WriteData      = 32'hFFFF_FFFF;
    Write          = 1'b1;   // attempted write while reset is held must be lost

    // ---- reset, then every register reads zero on all ports ----
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    Write = 1'b0;
    for (int i = 1; i < 32; i++) begin
      RegA = 5'(i);
      RegB = 5'(i);
      RegC = 5'(i);
      #1;
      check($sformatf("reset A r%0d", i), DataA, 32'd0);
      check($sformatf("reset B r%0d", i), DataB, 32'd0);
      check($sformatf("reset C r%0d", i), DataC, 32'd0);
    end

    // ---- write r5: old value before the edge, new value after ----
    @(negedge CLK);
    Write     = 1'b1;
    WriteReg  = 5'd5;
    WriteData = 32'hDEAD_BEEF;
    RegA      = 5'd5;
    #1;
    check("r5 before edge", DataA, 32'd0);
    @(posedge CLK);
    #1;
    Write = 1'b0;
    RegB  = 5'd5;
    RegC  = 5'd5;
    #1;
    check("r5 A after edge", DataA, 32'hDEAD_BEEF);
    check("r5 B after edge", DataB, 32'hDEAD_BEEF);
    check("r5 C after edge", DataC, 32'hDEAD_BEEF);

    // ---- write r0 is ignored ----
    @(negedge CLK);
    Write     = 1'b1;
    WriteReg  = 5'd0;
    WriteData = 32'h0000_1234;
    RegA      = 5'd0;
    @(posedge CLK);
    #1;
    Write = 1'b0;
    #1;
    check("r0 after write", DataA, 32'd0);

    // ---- top register, neighbour untouched ----
    @(negedge CLK);
    Write     = 1'b1;
    WriteReg  = 5'd31;
    WriteData = 32'hA5A5_5A5A;
    @(posedge CLK);
    #1;
    Write = 1'b0;
    RegA  = 5'd5;
    RegB  = 5'd30;
    RegC  = 5'd31;
    #1;
    check("r31 written", DataC, 32'hA5A5_5A5A);
    check("r30 untouched", DataB, 32'd0);
    check("r5 retained", DataA, 32'hDEAD_BEEF);

    // ---- async reset mid-cycle clears, overrides a concurrent write ----
    @(negedge CLK);
    Write     = 1'b1;
    WriteReg  = 5'd7;
    WriteData = 32'h0000_0077;
    #2;
    RESET = 1'b0;
    #1;
    check("async clr r5", DataA, 32'd0);
    check("async clr r31", DataC, 32'd0);
    @(posedge CLK);
    #1;
    RegB = 5'd7;
    #1;
    check("write during reset r7", DataB, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("r7 still 0 after release", DataB, 32'd0);
    @(posedge CLK);
    #1;
    Write = 1'b0;
    #1;
    check("r7 write resumes", DataB, 32'h0000_0077);

    // ---- decoder vectors ----
    check_decode("add",     32'h0085_1020, 32'h0040_0000, 32'h0,
                 11'b01000001000, 6'b100000, 32'h0040_4080);
    check_decode("jal",     32'h0C10_0004, 32'h0040_0008, 32'h0,
                 11'b10100001000, 6'b100001, 32'h0040_0010);
    check_decode("beq",     32'h1000_FFFF, 32'h0040_0104, 32'h0,
                 11'b00010000010, 6'b000000, 32'h0040_0100);
    check_decode("jr",      32'h03E0_0008, 32'h0040_0000, 32'h0040_0200,
                 11'b00100000100, 6'b000000, 32'h0040_0200);
    check_decode("syscall", 32'h0000_000C, 32'h0040_0000, 32'h0,
                 11'b00000000001, 6'b001100, 32'h0040_0030);
    check_decode("bad op",  32'hFC00_0000, 32'h0040_0000, 32'h0,
                 11'b00000000000, 6'b000000, 32'h0040_0000);
    check_decode("lw",      32'h8C82_0004, 32'h0000_1000, 32'h0,
                 11'b00001011010, 6'b110011, 32'h0000_1010);
    check_decode("sw",      32'hAC82_0008, 32'h0000_0000, 32'h0,
                 11'b00000110010, 6'b111011, 32'h0000_0020);
    check_decode("ori",     32'h3482_FFFF, 32'h0000_0100, 32'h0,
                 11'b00000011000, 6'b100101, 32'h0000_00FC);
    check_decode("bgezal",  32'h0491_0002, 32'h0040_0000, 32'h0,
                 11'b10010001010, 6'b100001, 32'h0040_0008);
    check_decode("jalr",    32'h0080_F809, 32'h0040_0000, 32'h1234_5678,
                 11'b11100001100, 6'b100001, 32'h1234_5678);
    check_decode("beq wrap", 32'h1000_7FFF, 32'hFFFF_FFF0, 32'h0,
                 11'b00010000010, 6'b000000, 32'h0001_FFEC);
    check_decode("j",       32'h0800_0001, 32'hF000_0000, 32'h0,
                 11'b00100000000, 6'b000000, 32'hF000_0004);
    check_decode("sc",      32'hE082_0000, 32'h0000_0000, 32'h0,
                 11'b00000111010, 6'b110110, 32'h0000_0000);
    check_decode("bad funct", 32'h0000_0001, 32'h0000_0000, 32'h0,
                 11'b00000000000, 6'b000000, 32'h0000_0004);
    check_decode("lui",     32'h3C01_1234, 32'h0000_0000, 32'h0,
                 11'b00000011000, 6'b011111, 32'h0000_48D0);
    check_decode("bad regimm", 32'h0402_0000, 32'h0000_0000, 32'h0,
                 11'b00000000000, 6'b000000, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
